// File: rtl/code_entry.sv
// Keypad digit-entry buffer for the six-digit lock: collects digits, handles
// backspace/clear/enter and holds a check request. Optional CODE_ENTRY_AUTO_ENTER_EN.
module code_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CHECK_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [2:0] cnt,
  output logic       check,
  output logic       busy,
  output logic       short_err,
  output logic       timeout
);

  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW         = $clog2(CHECK_CYCLES + 1);
  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_BKSP      = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    dig     [0:NUM_DIGITS-1];
  logic [3:0]    dig_nxt [0:NUM_DIGITS-1];
  logic [2:0]    cnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] ccnt, ccnt_nxt;
  logic          check_nxt, busy_nxt, short_nxt, timeout_nxt;
  logic          clear_all;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt   = state;
    for (int i = 0; i < NUM_DIGITS; i++) dig_nxt[i] = dig[i];
    cnt_nxt     = cnt;
    timer_nxt   = '0;
    ccnt_nxt    = ccnt;
    short_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    clear_all   = 1'b0;

    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (key_valid) begin
          if (key_code <= KEY_DIGIT_MAX) begin
            if (cnt < 3'd6) begin
              dig_nxt[cnt] = key_code;
              cnt_nxt      = cnt + 3'd1;
              state_nxt    = S_ENTRY;
`ifdef CODE_ENTRY_AUTO_ENTER_EN
              if (cnt == 3'd5) begin
                state_nxt = S_CHECK;
                ccnt_nxt  = CW'(CHECK_CYCLES);
              end
`endif
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                if (cnt != 3'd0) begin
                  dig_nxt[3'(cnt - 3'd1)] = 4'h0;
                  cnt_nxt                 = cnt - 3'd1;
                  if (cnt == 3'd1) state_nxt = S_IDLE;
                end
              end
              KEY_CLEAR: clear_all = 1'b1;
`ifndef CODE_ENTRY_AUTO_ENTER_EN
              KEY_ENTER: begin
                if (cnt == 3'd6) begin
                  state_nxt = S_CHECK;
                  ccnt_nxt  = CW'(CHECK_CYCLES);
                end else if (cnt != 3'd0) begin
                  clear_all = 1'b1;
                  short_nxt = 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end else if (state == S_ENTRY) begin
          // Inter-key timer; any key_valid above restarts it
          if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            clear_all   = 1'b1;
            timeout_nxt = 1'b1;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      S_CHECK: begin
        if (ccnt <= CW'(1)) state_nxt = S_DONE;
        else                ccnt_nxt  = ccnt - CW'(1);
      end
      S_DONE:  clear_all = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    if (clear_all) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_nxt[i] = 4'h0;
      cnt_nxt   = 3'd0;
      state_nxt = S_IDLE;
    end

    check_nxt = (state_nxt == S_CHECK);
    busy_nxt  = (state_nxt == S_CHECK) || (state_nxt == S_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= 4'h0;
      cnt       <= 3'd0;
      timer     <= '0;
      ccnt      <= '0;
      check     <= 1'b0;
      busy      <= 1'b0;
      short_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= dig_nxt[i];
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      ccnt      <= ccnt_nxt;
      check     <= check_nxt;
      busy      <= busy_nxt;
      short_err <= short_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign d1 = dig[0];
  assign d2 = dig[1];
  assign d3 = dig[2];
  assign d4 = dig[3];
  assign d5 = dig[4];
  assign d6 = dig[5];

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed test-plan sequences plus random
// keys, compared every cycle against a queue-based model of the entry rules.
module tb_code_entry;

  localparam int T = 10;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic [2:0] cnt;
  logic       check, busy, short_err, timeout;

  code_entry #(.TIMEOUT_CYCLES(T), .CHECK_CYCLES(C)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .cnt(cnt), .check(check), .busy(busy), .short_err(short_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: digit queue, remaining busy edges, idle count
  int q[$];
  int hold;
  int idle;
  bit e_short, e_to;

  function automatic void model_reset();
    q.delete();
    hold = 0; idle = 0; e_short = 0; e_to = 0;
  endfunction

  function automatic void model_step(input bit kv, input int kc);
    e_short = 0;
    e_to    = 0;
    if (hold > 0) begin
      hold--;
      if (hold == 0) q.delete();
    end else if (kv) begin
      idle = 0;
      if (kc <= 9) begin
        if (q.size() < 6) begin
          q.push_back(kc);
`ifdef CODE_ENTRY_AUTO_ENTER_EN
          if (q.size() == 6) hold = C + 1;
`endif
        end
      end else if (kc == 10) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (kc == 11) begin
        q.delete();
      end else if (kc == 14) begin
`ifndef CODE_ENTRY_AUTO_ENTER_EN
        if (q.size() == 6) hold = C + 1;
        else if (q.size() > 0) begin
          q.delete();
          e_short = 1;
        end
`endif
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle == T) begin
        q.delete();
        e_to = 1;
        idle = 0;
      end
    end else begin
      idle = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string where);
    logic [23:0] ed;
    ed = '0;
    for (int i = 0; i < q.size(); i++) ed[(5-i)*4 +: 4] = 4'(q[i]);
    chk({where, ":digits"}, 32'({d1, d2, d3, d4, d5, d6}), 32'(ed));
    chk({where, ":cnt"}, 32'(cnt), 32'(q.size()));
    chk({where, ":check"}, 32'(check), 32'(hold >= 2));
    chk({where, ":busy"}, 32'(busy), 32'(hold > 0));
    chk({where, ":short_err"}, 32'(short_err), 32'(e_short));
    chk({where, ":timeout"}, 32'(timeout), 32'(e_to));
  endtask

  // One clock with given inputs, model update, check after edge
  task automatic cyc(input bit kv, input int kc, input string where);
    key_valid = kv;
    key_code  = 4'(kc);
    @(posedge clk);
    model_step(kv, kc);
    #1;
    check_all(where);
    key_valid = 1'b0;
  endtask

  task automatic key(input int kc, input string where);
    cyc(1'b1, kc, where);
    cyc(1'b0, 0, where);
  endtask

  task automatic idle_n(input int n, input string where);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, where);
  endtask

  initial begin
    int r, sel, kc;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Full entry then enter
    for (int k = 1; k <= 6; k++) key(k, "full");
    key(14, "full_enter");
    idle_n(8, "full_check");

    // Backspace mid-entry, then backspace at empty
    key(7, "bs"); key(8, "bs"); key(10, "bs"); key(9, "bs");
    key(11, "bs_clear");
    key(10, "bs_empty"); key(10, "bs_empty");

    // Short enter
    key(1, "short"); key(2, "short"); key(3, "short");
    key(14, "short_enter");
    idle_n(3, "short_after");

    // Timeout, then near-timeout rescue
    cyc(1'b1, 5, "to_key");
    idle_n(T + 2, "to_idle");
    cyc(1'b1, 5, "nto_key");
    idle_n(T - 2, "nto_idle");
    cyc(1'b1, 6, "nto_key2");
    idle_n(3, "nto_after");
    key(11, "nto_clear");

    // Seven digits, enter, keys during CHECK, reset mid-CHECK
    for (int k = 0; k <= 6; k++) key(k, "seven");
    cyc(1'b1, 14, "seven_enter");
    cyc(1'b1, 3, "busy_key");
    cyc(1'b1, 11, "busy_key");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    #2;
    rst_n = 1'b1;
    idle_n(2, "post_reset");

`ifdef CODE_ENTRY_AUTO_ENTER_EN
    key(1, "auto_e"); key(2, "auto_e"); key(3, "auto_e");
    key(14, "auto_enter_ignored");
    key(11, "auto_clr");
    for (int k = 9; k >= 4; k--) cyc(1'b1, k, "auto");
    idle_n(7, "auto_check");
`endif

    // Randomized keys with occasional long idle gaps
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        sel = $urandom_range(0, 19);
        if (sel < 14)      kc = $urandom_range(0, 9);
        else if (sel < 16) kc = 10;
        else if (sel < 17) kc = 11;
        else if (sel < 19) kc = 14;
        else               kc = $urandom_range(12, 15);
        cyc(1'b1, kc, "rand");
      end else if (r == 9 && $urandom_range(0, 3) == 0) begin
        idle_n(T + 1, "rand_gap");
      end else begin
        cyc(1'b0, 0, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/code_entry.md
# code_entry

Keypad digit-entry buffer for the six-digit electronic lock, directly upstream of the password comparator. Collects keypad strobes into six 4-bit digit registers, supports backspace, clear and enter, and presents the completed code with a held check strobe that drives the comparator's start input. Partial entries are discarded on a short enter or on inter-key timeout.

## Interface
- TIMEOUT_CYCLES, 50_000_000: idle cycles (no key_valid) after which a partial entry is discarded; minimum 2.
- CHECK_CYCLES, 4: cycles `check` stays high per completed entry; minimum 1.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle key strobe from the debounced keypad.
- key_code  input  4  0x0–0x9 digit; 0xA backspace; 0xB clear; 0xE enter; all other codes ignored.
- d1..d6  output  4 each  entered digits; d1 is the first digit entered, unused positions read 0.
- cnt  output  3  number of digits held, 0–6.
- check  output  1  compare request to the comparator, level-held.
- busy  output  1  high in CHECK and DONE; keys are ignored.
- short_err  output  1  one-cycle pulse: enter pressed with cnt<6.
- timeout  output  1  one-cycle pulse: partial entry discarded by timer.

## Operation
- States: IDLE (cnt=0), ENTRY (1≤cnt≤6), CHECK, DONE. All outputs registered.
- Digit key, IDLE/ENTRY: if cnt<6, store into position cnt+1, cnt+1; IDLE→ENTRY. At cnt=6, digit ignored; no overwrite, no shift.
- Backspace: cnt>0 → position cnt cleared to 0, cnt−1; reaching 0 → IDLE. cnt=0 → ignored.
- Clear: all digits 0, cnt=0, → IDLE. No pulse.
- Enter, cnt=6: → CHECK. Enter, 1≤cnt≤5: digits cleared, cnt=0, short_err pulse, → IDLE. Enter at cnt=0: ignored.
- CHECK: check=1, d1..d6 held stable, down-counter runs CHECK_CYCLES cycles, then → DONE.
- DONE: one cycle, check=0, digits still held; next edge clears digits, cnt=0, → IDLE.
- Timer: cleared in IDLE/CHECK/DONE and on every key_valid (including ignored codes). In ENTRY it increments each cycle without key_valid; on reaching TIMEOUT_CYCLES, digits cleared, cnt=0, timeout pulse, → IDLE.
- Timer width: $clog2(TIMEOUT_CYCLES+1); CHECK counter width: $clog2(CHECK_CYCLES+1).

## Timing
- Reset values: d1..d6=0, cnt=0, check=0, busy=0, short_err=0, timeout=0, state IDLE, counters 0.
- Key sampled at rising edge with key_valid=1; d/cnt updated on that edge (visible the following cycle).
- Enter sampled at edge N → check and busy high from edge N through edge N+CHECK_CYCLES; check low after edge N+CHECK_CYCLES; busy low and digits 0 after edge N+CHECK_CYCLES+1.
- Timer expiry and key_valid on the same edge: key wins, timer restarts, no timeout.
- key_valid during CHECK/DONE: dropped, no side effect.
- rst_n low at any point (incl. mid-CHECK): all outputs to reset values immediately; check falls asynchronously.

## Configuration
- CODE_ENTRY_AUTO_ENTER_EN defined: accepting the sixth digit transitions directly to CHECK on that same edge (check high the following cycle); enter key is then ignored in all states, so short_err never pulses.
- Undefined: enter key required as described above; sixth digit leaves state in ENTRY.

## Test plan
- Keys 1,2,3,4,5,6,enter → d1..d6=1..6, cnt=6; check high exactly CHECK_CYCLES=4 cycles; digits 0 and busy low 2 cycles after check rises +3.
- Keys 7,8,backspace,9 → d1=7, d2=9, cnt=2; backspace at cnt=0 → no change.
- Keys 1,2,3,enter → short_err single pulse, cnt=0, all digits 0, check never rises.
- TIMEOUT_CYCLES=10: key 5 then idle 10 cycles → timeout pulse, cnt=0; repeat with key at 9th idle cycle → no timeout, cnt=2.
- Seven digits 0..6 then enter → d1..d6=0..5 (seventh ignored); key strobes during CHECK ignored; rst_n low mid-CHECK → check=0, cnt=0 immediately.
- With CODE_ENTRY_AUTO_ENTER_EN: keys 9,8,7,6,5,4 → check rises the cycle after the sixth key with no enter; enter at cnt=3 → ignored, no short_err.
